// File: rtl/return_stack.sv
// Return-address stack feeding the PC mux; top is combinational from registered state.
// Define RSTACK_CIRCULAR_EN to make a push on a full stack overwrite the oldest entry.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_inc;
  logic [AW-1:0]    sp_dec;
  logic             we;
  logic [AW-1:0]    waddr;

  assign sp_inc = sp + AW'(1);
  assign sp_dec = sp - AW'(1);
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign top    = empty ? '0 : mem[sp_dec];

  // Push+pop on a non-empty stack rewrites the top in place; every other push targets sp.
  always_comb begin
    we    = 1'b0;
    waddr = sp;
    if (!reset && push) begin
      if (pop && !empty) begin
        we    = 1'b1;
        waddr = sp_dec;
      end else if (!full) begin
        we = 1'b1;
      end else begin
`ifdef RSTACK_CIRCULAR_EN
        we = 1'b1;
`else
        we = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // clr_err is applied first so a same-cycle set condition wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (push && pop) begin
        if (empty) begin
          sp    <= sp_inc;
          count <= count + (AW+1)'(1);
          unf   <= 1'b1;
        end
      end else if (push) begin
        if (!full) begin
          sp    <= sp_inc;
          count <= count + (AW+1)'(1);
        end else begin
          ovf <= 1'b1;
`ifdef RSTACK_CIRCULAR_EN
          sp  <= sp_inc;
`endif
        end
      end else if (pop) begin
        if (!empty) begin
          sp    <= sp_dec;
          count <= count - (AW+1)'(1);
        end else begin
          unf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the 8-bit processor. It sits directly upstream of the 10-bit program-counter register and its input multiplexer. On a subroutine call it stores the return address (PC+1 from the PC adder). On a return it presents the most recent address on `top`, which the PC mux selects as the next PC in the same cycle as the pop.

## Interface

**Parameters**
- `DEPTH`, 8: number of entries; must be a power of two, minimum 2.
- `WIDTH`, 10: address width; matches the PC width.

**Ports**
- `clk`  input  1: system clock; all state changes on the rising edge.
- `reset`  input  1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `push`  input  1: store `din` as the new top (call instruction).
- `pop`  input  1: remove the top entry (return instruction).
- `din`  input  WIDTH: return address to push.
- `clr_err`  input  1: synchronous clear of `ovf` and `unf`.
- `top`  output  WIDTH: current top entry; combinational from registered state; 0 when empty.
- `count`  output  $clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`  output  1: `count == 0`.
- `full`  output  1: `count == DEPTH`.
- `ovf`  output  1: sticky overflow flag.
- `unf`  output  1: sticky underflow flag.

## Operation

**Storage**
- `DEPTH` x `WIDTH` register array, plus stack pointer `sp` ($clog2(DEPTH) bits) that points to the next free slot.
- `top` = `mem[sp-1]` (modulo DEPTH) when `count != 0`, else 0.
- All pointer arithmetic is modulo DEPTH; `sp` wraps naturally.

**Per-cycle action** (priority: `reset` > operation decode; `clr_err` is evaluated with the operation decode):
- **Idle** (`push=0`, `pop=0`): no change.
- **Push only**, not full: `mem[sp] <= din`, `sp <= sp+1`, `count <= count+1`.
- **Push only**, full: see Configuration.
- **Pop only**, not empty: `sp <= sp-1`, `count <= count-1`. Memory is unchanged.
- **Pop only**, empty: no change to `sp` or `count`; `unf <= 1`.
- **Push and pop**, not empty: replace top, i.e. `mem[sp-1] <= din`; `sp` and `count` unchanged. Never sets `ovf`, including when full.
- **Push and pop**, empty: treated as push only (`mem[sp] <= din`, count becomes 1); `unf <= 1`.

**Error flags**
- `ovf` and `unf` are set only as described above and held until `reset` or `clr_err`.
- If a set condition and `clr_err` occur in the same cycle, the set wins and the flag reads 1 next cycle.

**Reset**
- `sp`, `count`, `ovf` and `unf` go to 0, so `empty=1`, `full=0`, `top=0`.
- Memory contents are not cleared; they are unobservable while empty.
- Reset asserted mid-sequence discards all entries, and any push or pop in that cycle is ignored.

## Timing

- Push and pop take effect at the rising edge where they are sampled. `count`, `empty`, `full` and `top` reflect the new state immediately after that edge.
- `top` has zero-cycle latency from state: a return reads `top` and asserts `pop` in the same cycle.
- A push followed by a pop on the next cycle returns the pushed `din` on `top` during the pop cycle.
- Flags update one edge after their triggering condition.
- No combinational path exists from `push`, `pop` or `din` to any output.

## Configuration

The single configuration macro is `RSTACK_CIRCULAR_EN`. It only changes the "push only, full" case.

- **Defined:** the push overwrites the oldest entry. `mem[sp] <= din`, `sp <= sp+1`, `count` stays DEPTH, and `ovf <= 1`. The stack then holds the DEPTH most recent addresses.
- **Not defined:** the push is dropped. `sp`, `count` and memory are unchanged, and `ovf <= 1`.

## Test plan

- **Reset state:** assert `reset` for 1 cycle -> `count=0`, `empty=1`, `full=0`, `top=0`, `ovf=0`, `unf=0`.
- **LIFO order:** push 0x011, 0x022, 0x3FF on consecutive cycles, then pop 3 cycles -> `top` reads 0x3FF, 0x022, 0x011 during the pop cycles, then `empty=1`, `top=0`.
- **Underflow:** pop when empty -> `count` stays 0, `unf=1` next cycle. Then `clr_err` -> `unf=0`. Then `clr_err` with a pop on empty in the same cycle -> `unf=1`.
- **Overflow:** push 0x001..0x009 with DEPTH=8.
  - Without the macro: `count=8`, `top=0x008`, `ovf=1`; popping 8 times yields 0x008..0x001.
  - With `RSTACK_CIRCULAR_EN`: `top=0x009`, `ovf=1`; popping 8 times yields 0x009..0x002.
- **Simultaneous push and pop:**
  - Stack holds 0x050, 0x060 -> after push+pop with `din=0x070`, `top=0x070`, `count=2`.
  - Empty stack, push+pop with `din=0x123` -> `count=1`, `top=0x123`, `unf=1`.
- **Reset mid-operation:** push 3 entries, then assert `reset` together with `push` (`din=0x2AA`) -> next cycle `count=0`, `top=0`, and a following pop sets `unf`.
